gamma_corrector: RTL and testbench

- Per-channel gamma/tone-curve stage directly downstream of color_corrector; consumes its clipped R/G/B AXI4-Stream video.
- Each pixel component indexes a programmable 2^PX_WIDTH-entry LUT.
- LUTs are double-banked: software writes the shadow bank, and the bank swap is applied only at a frame boundary (tuser), so frames never tear.
- Self-initialises both banks to identity after reset.

---
 rtl/gamma_pkg.sv | 24 ++
 rtl/axi4_stream_if.sv | 19 +
 rtl/gamma_lut_ram.sv | 43 ++++
 rtl/gamma_corrector.sv | 186 ++++++++++++++++++
 tb/tb_gamma_corrector.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gamma_pkg.sv
// Shared types for the gamma corrector: LUT channel select, control FSM states, bank select.
package gamma_pkg;

    typedef enum logic [1:0] {
        CH_R   = 2'd0,
        CH_G   = 2'd1,
        CH_B   = 2'd2,
        CH_ALL = 2'd3
    } chan_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    typedef logic bank_t;

    // Three components packed, rounded up to whole bytes.
    function automatic int tdata_width(input int px);
        return ((3 * px + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; tuser is a single start-of-frame bit.
interface axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4
) ();
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic                tuser;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/gamma_lut_ram.sv
// Two-bank LUT RAM: port A writes one or both banks (readback if GAMMA_READBACK_EN), port B reads.
// Both reads are registered, 1 cycle; port B holds its output while b_en is low.
module gamma_lut_ram
    import gamma_pkg::*;
#(
    parameter int PX_WIDTH = 10
) (
    input  logic                clk_i,
    input  logic                a_we,
    input  logic                a_we_both,
    input  bank_t               a_bank,
    input  logic [PX_WIDTH-1:0] a_addr,
    input  logic [PX_WIDTH-1:0] a_wdata,
    output logic [PX_WIDTH-1:0] a_rdata,
    input  logic                b_en,
    input  bank_t               b_bank,
    input  logic [PX_WIDTH-1:0] b_addr,
    output logic [PX_WIDTH-1:0] b_rdata
);
    localparam int DEPTH = 2 ** PX_WIDTH;

    // Bank bit is the address MSB; split so init can fill both halves at once.
    logic [PX_WIDTH-1:0] bank0_mem [DEPTH];
    logic [PX_WIDTH-1:0] bank1_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (a_we && (a_we_both || !a_bank)) bank0_mem[a_addr] <= a_wdata;
        if (a_we && (a_we_both || a_bank))  bank1_mem[a_addr] <= a_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (b_en) b_rdata <= b_bank ? bank1_mem[b_addr] : bank0_mem[b_addr];
    end

`ifdef GAMMA_READBACK_EN
    always_ff @(posedge clk_i) begin
        a_rdata <= a_bank ? bank1_mem[a_addr] : bank0_mem[a_addr];
    end
`else
    assign a_rdata = '0;
`endif

endmodule

// File: rtl/gamma_corrector.sv
// Per-channel double-banked gamma LUT on AXI4-Stream video; optional readback via GAMMA_READBACK_EN.
// Latency 2 cycles accept-to-tvalid; full throughput, each stage stalls in place under backpressure.
module gamma_corrector
    import gamma_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int TDATA_WIDTH = tdata_width(PX_WIDTH),
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    axi4_stream_if.slave          video_i,
    axi4_stream_if.master         video_o,
    input  logic                  lut_wr_i,
    input  logic [1:0]            lut_chan_i,
    input  logic [PX_WIDTH-1:0]   lut_addr_i,
    input  logic [PX_WIDTH-1:0]   lut_data_i,
    input  logic                  lut_commit_i,
    output logic                  lut_pending_o,
    output logic                  lut_busy_o,
    output logic [3*PX_WIDTH-1:0] lut_rd_data_o
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int PW = PX_WIDTH;

    typedef struct packed {
        logic                  last;
        logic                  user;
        logic [KW-1:0]         keep;
        logic [KW-1:0]         strb;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
    } side_t;

    state_e                 state_q, state_d;
    logic [PW-1:0]          init_cnt_q;
    bank_t                  active_q, rd_bank;
    logic                   in_rdy, in_fire, swap, s1_load, s2_load;
    logic                   s1_vld_q, s2_vld_q;
    side_t                  in_side, s1_side_q, s2_side_q;
    logic [TDATA_WIDTH-1:0] s2_dat_q;
    chan_e                  chan;

    // Channel arrays indexed 0=R, 1=G, 2=B.
    logic [2:0]    a_we;
    logic          a_we_both;
    bank_t         a_bank;
    logic [PW-1:0] a_addr, a_wdata;
    logic [PW-1:0] a_rdata [3];
    logic [PW-1:0] b_rdata [3];
    logic [PW-1:0] b_addr  [3];

    assign chan    = chan_e'(lut_chan_i);
    assign s2_load = !s2_vld_q || video_o.tready;
    assign s1_load = !s1_vld_q || s2_load;
    assign in_rdy  = (state_q != ST_INIT) && s1_load;
    assign in_fire = video_i.tvalid && in_rdy;
    assign swap    = (state_q == ST_PEND) && in_fire && video_i.tuser;
    // The swapping beat itself must already read the new bank.
    assign rd_bank = swap ? ~active_q : active_q;

    assign video_i.tready = in_rdy;
    assign b_addr[1] = video_i.tdata[PW-1:0];
    assign b_addr[2] = video_i.tdata[2*PW-1:PW];
    assign b_addr[0] = video_i.tdata[3*PW-1:2*PW];
    assign in_side   = '{last: video_i.tlast, user: video_i.tuser, keep: video_i.tkeep,
                         strb: video_i.tstrb, id: video_i.tid, dest: video_i.tdest};

    generate
        if (TDATA_WIDTH > 3 * PW) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^video_i.tdata[TDATA_WIDTH-1:3*PW];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        lut_busy_o    = 1'b1;
        lut_pending_o = 1'b0;
        case (state_q)
            ST_INIT: if (init_cnt_q == '1) state_d = ST_RUN;
            ST_RUN: begin
                lut_busy_o = 1'b0;
                if (lut_commit_i) state_d = ST_PEND;
            end
            ST_PEND: begin
                lut_pending_o = 1'b1;
                if (swap) state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
            if (swap) active_q <= ~active_q;
        end
    end

    // Host writes only land in the shadow bank, so port B never collides with them.
    always_comb begin
        a_we      = '0;
        a_we_both = 1'b0;
        a_bank    = ~active_q;
        a_addr    = lut_addr_i;
        a_wdata   = lut_data_i;
        if (state_q == ST_INIT) begin
            a_we      = '1;
            a_we_both = 1'b1;
            a_addr    = init_cnt_q;
            a_wdata   = init_cnt_q;
        end else if (state_q == ST_RUN && lut_wr_i) begin
            a_we[0] = (chan == CH_R) || (chan == CH_ALL);
            a_we[1] = (chan == CH_G) || (chan == CH_ALL);
            a_we[2] = (chan == CH_B) || (chan == CH_ALL);
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        gamma_lut_ram #(.PX_WIDTH(PW)) u_ram (
            .clk_i     (clk_i),
            .a_we      (a_we[c]),
            .a_we_both (a_we_both),
            .a_bank    (a_bank),
            .a_addr    (a_addr),
            .a_wdata   (a_wdata),
            .a_rdata   (a_rdata[c]),
            .b_en      (s1_load),
            .b_bank    (rd_bank),
            .b_addr    (b_addr[c]),
            .b_rdata   (b_rdata[c])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld_q  <= 1'b0;
            s1_side_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_side_q <= '0;
            s2_dat_q  <= '0;
        end else begin
            if (s1_load) begin
                s1_vld_q  <= in_fire;
                s1_side_q <= in_side;
            end
            if (s2_load) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_side_q <= s1_side_q;
                    s2_dat_q  <= TDATA_WIDTH'({b_rdata[0], b_rdata[2], b_rdata[1]});
                end
            end
        end
    end

    assign video_o.tvalid = s2_vld_q;
    assign video_o.tdata  = s2_dat_q;
    assign video_o.tlast  = s2_side_q.last;
    assign video_o.tuser  = s2_side_q.user;
    assign video_o.tkeep  = s2_side_q.keep;
    assign video_o.tstrb  = s2_side_q.strb;
    assign video_o.tid    = s2_side_q.id;
    assign video_o.tdest  = s2_side_q.dest;

`ifdef GAMMA_READBACK_EN
    logic rd_vld_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_vld_q <= 1'b0;
        else          rd_vld_q <= (state_q != ST_INIT);
    end
    assign lut_rd_data_o = rd_vld_q ? {a_rdata[0], a_rdata[2], a_rdata[1]} : '0;
`else
    logic unused_rd;
    assign unused_rd     = ^{a_rdata[0], a_rdata[1], a_rdata[2]};
    assign lut_rd_data_o = '0;
`endif

endmodule

// File: tb/tb_gamma_corrector.sv
// Random-stimulus bench for gamma_corrector: LUT/bank model feeds an expectation queue, a monitor pops it.
module tb_gamma_corrector;
    localparam int PX = 10;
    localparam int DW = 32;
    localparam int INIT_CYCLES = 1024;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic          user;
        logic [3:0]    keep;
        logic [3:0]    strb;
        logic [3:0]    id;
        logic [3:0]    dest;
    } beat_t;

    logic clk, rst_n;
    logic lut_wr, lut_commit, lut_pending, lut_busy;
    logic [1:0] lut_chan;
    logic [PX-1:0] lut_addr, lut_data;
    logic [3*PX-1:0] lut_rd_data;

    axi4_stream_if #(.DATA_W(DW)) in_if ();
    axi4_stream_if #(.DATA_W(DW)) out_if ();

    gamma_corrector #(.PX_WIDTH(PX)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .video_i       (in_if),
        .video_o       (out_if),
        .lut_wr_i      (lut_wr),
        .lut_chan_i    (lut_chan),
        .lut_addr_i    (lut_addr),
        .lut_data_i    (lut_data),
        .lut_commit_i  (lut_commit),
        .lut_pending_o (lut_pending),
        .lut_busy_o    (lut_busy),
        .lut_rd_data_o (lut_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int out_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready

    // Reference model: two banks of three plain lookup tables.
    logic [PX-1:0] lut [2][3][1024];
    bit    active, pending, pend_now, in_init;
    int    cyc;
    beat_t exp_q[$];
    beat_t e, got;
    bit    prev_stall;
    logic [DW-1:0] prev_dat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; pending = 0; active = 0;
            exp_q.delete();
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 3; c++)
                    for (int a = 0; a < 1024; a++) lut[b][c][a] = PX'(a);
        end else begin
            in_init  = (cyc < INIT_CYCLES);
            pend_now = pending;
            checks++;
            if (lut_pending !== pending || lut_busy !== (in_init || pending)) begin
                errors++;
                $display("FAIL status cyc=%0d pending=%b busy=%b expected pending=%b busy=%b",
                         cyc, lut_pending, lut_busy, pending, in_init || pending);
            end
            if (in_if.tvalid && in_if.tready) begin
                if (pending && in_if.tuser) begin
                    active  = !active;
                    pending = 0;
                end
                e.dat  = {2'b00, lut[active][0][in_if.tdata[29:20]],
                          lut[active][2][in_if.tdata[19:10]], lut[active][1][in_if.tdata[9:0]]};
                e.last = in_if.tlast; e.user = in_if.tuser;
                e.keep = in_if.tkeep; e.strb = in_if.tstrb;
                e.id   = in_if.tid;   e.dest = in_if.tdest;
                exp_q.push_back(e);
            end
            if (!in_init && !pend_now) begin
                if (lut_wr)
                    for (int c = 0; c < 3; c++)
                        if (lut_chan == 2'd3 || int'(lut_chan) == c) lut[!active][c][lut_addr] = lut_data;
                if (lut_commit) pending = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) check("hold_stable", {out_if.tvalid, out_if.tdata}, {1'b1, prev_dat});
            if (out_if.tvalid && out_if.tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output actual=%h expected=none", out_if.tdata);
                end else begin
                    e   = exp_q.pop_front();
                    got = {out_if.tdata, out_if.tlast, out_if.tuser, out_if.tkeep,
                           out_if.tstrb, out_if.tid, out_if.tdest};
                    checks++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat n=%0d actual=%h expected=%h", n_out, got, e);
                    end
                end
            end
            prev_stall = out_if.tvalid && !out_if.tready;
            prev_dat   = out_if.tdata;
        end
    end

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (out_mode)
                0:       out_if.tready = 1'b1;
                1:       out_if.tready = 1'($urandom_range(0, 1));
                default: out_if.tready = 1'b0;
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_pulse(input logic [1:0] ch, input logic [PX-1:0] a, input logic [PX-1:0] d);
        lut_wr = 1; lut_chan = ch; lut_addr = a; lut_data = d;
        @(posedge clk); #1;
        lut_wr = 0;
    endtask

    task automatic commit_pulse();
        lut_commit = 1;
        @(posedge clk); #1;
        lut_commit = 0;
    endtask

    task automatic send_beat(input logic [PX-1:0] r, input logic [PX-1:0] g, input logic [PX-1:0] b,
                             input bit user, input bit last);
        int waited;
        in_if.tdata  = {2'b00, r, b, g};
        in_if.tuser  = user;
        in_if.tlast  = last;
        in_if.tkeep  = 4'hf;
        in_if.tstrb  = 4'($urandom);
        in_if.tid    = 4'($urandom);
        in_if.tdest  = 4'($urandom);
        in_if.tvalid = 1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_if.tready) break;
            waited++;
            if (waited > 300) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=stalled expected=tready");
                break;
            end
        end
        @(posedge clk); #1;
        in_if.tvalid = 0;
    endtask

    task automatic init_check(input string name);
        int low;
        low = 0;
        forever begin
            @(negedge clk);
            if (in_if.tready || low > 2000) break;
            low++;
            @(posedge clk); #1;
            lut_wr     = (low == 10);
            lut_chan   = 2'd3; lut_addr = 10'd5; lut_data = 10'd1023;
            lut_commit = (low == 20);
        end
        check(name, low, INIT_CYCLES);
        @(posedge clk); #1;
        lut_wr = 0; lut_commit = 0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        rst_n = 0; lut_wr = 0; lut_commit = 0; lut_chan = 0; lut_addr = 0; lut_data = 0;
        in_if.tvalid = 0; in_if.tdata = 0; in_if.tuser = 0; in_if.tlast = 0;
        in_if.tkeep = 0; in_if.tstrb = 0; in_if.tid = 0; in_if.tdest = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", in_if.tready, 0);
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tdata", out_if.tdata, 0);
        check("rst_busy", lut_busy, 1);
        check("rst_pending", lut_pending, 0);
        check("rst_rd_data", lut_rd_data, 0);
        @(posedge clk); #1;
        rst_n = 1;
        init_check("init_tready_low_cycles");

        // Identity mapping and 2-cycle latency
        send_beat(10'd5, 10'd700, 10'd1023, 1, 0);
        @(negedge clk); check("latency_cycle1_tvalid", out_if.tvalid, 0);
        @(posedge clk); #1;
        @(negedge clk); check("latency_cycle2_tvalid", out_if.tvalid, 1);
        check("identity_tdata", out_if.tdata, {2'b00, 10'd5, 10'd1023, 10'd700});
        @(posedge clk); #1;

        // Swap only at the next frame start
        wr_pulse(2'd3, 10'd512, 10'd100);
        commit_pulse();
        check("pending_after_commit", lut_pending, 1);
        check("busy_in_pend", lut_busy, 1);
        repeat (3) send_beat(10'd512, 10'd512, 10'd512, 0, 0);
        send_beat(10'd512, 10'd512, 10'd512, 1, 0);
        check("pending_cleared_on_swap", lut_pending, 0);
        send_beat(10'd512, 10'd512, 10'd512, 0, 1);
        wait_drain("swap_drain");

        // Writes while pending are dropped
        commit_pulse();
        wr_pulse(2'd3, 10'd0, 10'd1023);
        send_beat(10'd0, 10'd0, 10'd0, 1, 0);
        send_beat(10'd0, 10'd0, 10'd0, 0, 1);
        wait_drain("pend_write_drain");

        // Commit in the same cycle as an accepted start-of-frame beat
        wr_pulse(2'd1, 10'd200, 10'd33);
        in_if.tdata = {2'b00, 10'd0, 10'd0, 10'd200};
        in_if.tuser = 1; in_if.tlast = 0; in_if.tvalid = 1; lut_commit = 1;
        @(negedge clk); check("same_cycle_tready", in_if.tready, 1);
        @(posedge clk); #1;
        in_if.tvalid = 0; lut_commit = 0;
        check("same_cycle_pending", lut_pending, 1);
        send_beat(10'd0, 10'd200, 10'd0, 0, 0);
        send_beat(10'd0, 10'd200, 10'd0, 1, 0);
        send_beat(10'd0, 10'd200, 10'd0, 0, 1);
        wait_drain("same_cycle_drain");

        // Random LUT and a 1000-beat frame under random backpressure
        for (int i = 0; i < 64; i++) wr_pulse(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom));
        commit_pulse();
        out_mode = 1;
        base = n_out;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            send_beat(10'($urandom), 10'($urandom), 10'($urandom), i == 0, (i % 100) == 99);
        end
        wait_drain("random_frame_drain");
        out_mode = 0;
        check("random_frame_beats", n_out - base, 1000);
        idle(1);

        // Shadow-bank readback
        wr_pulse(2'd1, 10'd3, 10'd77);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef GAMMA_READBACK_EN
        check("readback_g", lut_rd_data[9:0], 77);
`else
        check("readback_off", lut_rd_data, 0);
`endif
        @(posedge clk); #1;

        // Reset with beats in flight
        out_mode = 2;
        idle(1);
        send_beat(10'($urandom), 10'($urandom), 10'($urandom), 1, 0);
        send_beat(10'($urandom), 10'($urandom), 10'($urandom), 0, 0);
        check("inflight_before_reset", out_if.tvalid, 1);
        rst_n = 0;
        #1;
        check("rst_async_tvalid", out_if.tvalid, 0);
        @(negedge clk);
        check("midrst_tvalid", out_if.tvalid, 0);
        check("midrst_tready", in_if.tready, 0);
        check("midrst_busy", lut_busy, 1);
        check("midrst_pending", lut_pending, 0);
        @(posedge clk); #1;
        out_mode = 0;
        idle(1);
        rst_n = 1;
        init_check("reinit_tready_low_cycles");
        send_beat(10'($urandom), 10'($urandom), 10'($urandom), 1, 0);
        send_beat(10'd512, 10'd3, 10'd200, 0, 1);
        wait_drain("post_reset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
